// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-bank write arbiter.
package reg_arb_pkg;

    // Sequencer states: normal arbitration or bulk-clear sweep
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

    // Default geometry of the bank and requester set
    localparam int DEF_NREQ = 4;
    localparam int DEF_NREG = 8;
    localparam int DEF_DW   = 8;

    // Index widths; a width is never allowed to collapse to zero bits
    localparam int DEF_REQ_IW = (DEF_NREQ > 1) ? $clog2(DEF_NREQ) : 1;
    localparam int DEF_REG_IW = (DEF_NREG > 1) ? $clog2(DEF_NREG) : 1;

    // Bits needed to index n items, with a minimum of one bit
    function automatic int idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Rotating priority encoder: finds the first set bit of the eligible mask
// at or after the round-robin pointer, wrapping from the top index to 0.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = idx_w(DEF_NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    // Scan NREQ positions starting at ptr; the first hit wins
    always_comb begin
        valid = 1'b0;
        idx   = {IW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            int pos;
            pos = (int'(ptr) + i) % NREQ;
            if (!valid && eligible[pos]) begin
                valid = 1'b1;
                idx   = IW'(pos);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write-port arbiter for an enable-gated register bank, with a
// one-register-per-cycle bulk-clear sweep. All outputs come from flops.
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int NREG = DEF_NREG,
    parameter int DW   = DEF_DW
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NREQ-1:0]                  req,
    input  logic [NREQ*idx_w(NREG)-1:0]      req_addr,
    input  logic [NREQ*DW-1:0]               req_data,
    output logic [NREQ-1:0]                  gnt,
    output logic [NREG-1:0]                  wr_enb,
    output logic [DW-1:0]                    wr_data,
    input  logic                             clr_req,
    output logic                             busy,
    output logic                             clr_done
);

    localparam int RIW = idx_w(NREQ);
    localparam int AIW = idx_w(NREG);
    // The clear counter must be able to hold NREG itself (end-of-sweep marker)
    localparam int CW  = $clog2(NREG + 1);

    arb_state_e        state_r;
    logic [CW-1:0]     cnt_r;
    logic [RIW-1:0]    rr_ptr_r;
    logic [NREQ-1:0]   gnt_r;
    logic [NREG-1:0]   wr_enb_r;
    logic [DW-1:0]     wr_data_r;
    logic              busy_r;
    logic              clr_done_r;

    logic [NREQ-1:0]   eligible_s;
    logic              pick_valid_s;
    logic [RIW-1:0]    pick_idx_s;
    logic [AIW-1:0]    sel_addr_s;
    logic [DW-1:0]     sel_data_s;
    logic [NREQ-1:0]   arb_gnt_s;
    logic [NREG-1:0]   arb_enb_s;
    logic [DW-1:0]     arb_data_s;
    logic [RIW-1:0]    arb_ptr_s;

    // One-hot decode of a register index; out-of-range indices decode to no write
    function automatic logic [NREG-1:0] reg_onehot(input logic [CW-1:0] a);
        logic [NREG-1:0] r;
        if (int'(a) < NREG) begin
            r = {{(NREG-1){1'b0}}, 1'b1} << a;
        end else begin
            r = {NREG{1'b0}};
        end
        return r;
    endfunction

    // A requester already holding this cycle's grant must not win again
    assign eligible_s = req & ~gnt_r;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (RIW)
    ) u_rr_pick (
        .eligible (eligible_s),
        .ptr      (rr_ptr_r),
        .valid    (pick_valid_s),
        .idx      (pick_idx_s)
    );

    // Select the winning requester's address and data from the packed buses
    always_comb begin
        sel_addr_s = req_addr[int'(pick_idx_s)*AIW +: AIW];
        sel_data_s = req_data[int'(pick_idx_s)*DW +: DW];
    end

    // Next-state values for an arbitration edge (all zero when nobody is eligible)
    always_comb begin
        arb_gnt_s  = {NREQ{1'b0}};
        arb_enb_s  = {NREG{1'b0}};
        arb_data_s = {DW{1'b0}};
        arb_ptr_s  = rr_ptr_r;
        if (pick_valid_s) begin
            arb_gnt_s  = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
            arb_enb_s  = reg_onehot(CW'(sel_addr_s));
            arb_data_s = sel_data_s;
            if (int'(pick_idx_s) == NREQ - 1) begin
                arb_ptr_s = {RIW{1'b0}};
            end else begin
                arb_ptr_s = pick_idx_s + RIW'(1);
            end
        end else begin
            arb_ptr_s = rr_ptr_r;
        end
    end

    // Sequencer: arbitration in IDLE, one cleared register per edge in CLEAR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            rr_ptr_r   <= {RIW{1'b0}};
            gnt_r      <= {NREQ{1'b0}};
            wr_enb_r   <= {NREG{1'b0}};
            wr_data_r  <= {DW{1'b0}};
            busy_r     <= 1'b0;
            clr_done_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    clr_done_r <= 1'b0;
                    if (clr_req) begin
                        // Register 0 is written on the entry edge; cnt points at the next one
                        state_r   <= CLEAR;
                        cnt_r     <= CW'(1);
                        gnt_r     <= {NREQ{1'b0}};
                        wr_enb_r  <= reg_onehot({CW{1'b0}});
                        wr_data_r <= {DW{1'b0}};
                        busy_r    <= 1'b1;
                    end else begin
                        gnt_r     <= arb_gnt_s;
                        wr_enb_r  <= arb_enb_s;
                        wr_data_r <= arb_data_s;
                        rr_ptr_r  <= arb_ptr_s;
                        busy_r    <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (int'(cnt_r) < NREG) begin
                        // Mid-sweep: new clear requests are ignored, pointer frozen
                        cnt_r      <= cnt_r + CW'(1);
                        gnt_r      <= {NREQ{1'b0}};
                        wr_enb_r   <= reg_onehot(cnt_r);
                        wr_data_r  <= {DW{1'b0}};
                        busy_r     <= 1'b1;
                        clr_done_r <= 1'b0;
                    end else begin
                        // Sweep complete; arbitration resumes on this same edge
                        state_r    <= IDLE;
                        cnt_r      <= {CW{1'b0}};
                        busy_r     <= 1'b0;
                        clr_done_r <= 1'b1;
                        gnt_r      <= arb_gnt_s;
                        wr_enb_r   <= arb_enb_s;
                        wr_data_r  <= arb_data_s;
                        rr_ptr_r   <= arb_ptr_s;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= {CW{1'b0}};
                    gnt_r      <= {NREQ{1'b0}};
                    wr_enb_r   <= {NREG{1'b0}};
                    wr_data_r  <= {DW{1'b0}};
                    busy_r     <= 1'b0;
                    clr_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt      = gnt_r;
    assign wr_enb   = wr_enb_r;
    assign wr_data  = wr_data_r;
    assign busy     = busy_r;
    assign clr_done = clr_done_r;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter with a behavioural bank.
module tb_reg_bank_arbiter;

    localparam int NREQ = 4;
    localparam int NREG = 8;
    localparam int DW   = 8;
    localparam int AIW  = 3;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*AIW-1:0]  req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic [NREG-1:0]      wr_enb;
    logic [DW-1:0]        wr_data;
    logic                 clr_req;
    logic                 busy;
    logic                 clr_done;

    logic [DW-1:0]        bank [NREG];

    int checks;
    int errors;

    reg_bank_arbiter #(.NREQ(NREQ), .NREG(NREG), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .wr_enb   (wr_enb),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External register bank fed by the arbiter's enables and data
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (wr_enb[i]) bank[i] <= wr_data;
        end
    end

    task automatic set_req(input int k, input logic [AIW-1:0] a, input logic [DW-1:0] d);
        req[k] = 1'b1;
        req_addr[k*AIW +: AIW] = a;
        req_data[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        clr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = '0; req_addr = '0; req_data = '0; clr_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        checks++; if (wr_enb !== 8'h00) begin errors++; $display("FAIL reset_wr_enb got %h want 00", wr_enb); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
        checks++; if (busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, clr_done); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        set_req(2, 3'd5, 8'hA7);
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want 0100", gnt); end
        checks++; if (wr_enb !== 8'h20) begin errors++; $display("FAIL single_wr_enb got %h want 20", wr_enb); end
        checks++; if (wr_data !== 8'hA7) begin errors++; $display("FAIL single_wr_data got %h want a7", wr_data); end
        req = '0;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000 || wr_enb !== 8'h00) begin errors++; $display("FAIL single_after got gnt=%b enb=%h want 0000 00", gnt, wr_enb); end
        checks++; if (bank[5] !== 8'hA7) begin errors++; $display("FAIL single_reg5 got %h want a7", bank[5]); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_gnt [5];
        int exp_idx [5];
        exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
        exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
        exp_idx[0] = 0; exp_idx[1] = 1; exp_idx[2] = 2; exp_idx[3] = 3; exp_idx[4] = 0;
        do_reset();
        for (int k = 0; k < NREQ; k++) set_req(k, AIW'(k), 8'(8'h10 + k));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (gnt !== exp_gnt[c]) begin errors++; $display("FAIL rr_gnt[%0d] got %b want %b", c, gnt, exp_gnt[c]); end
            checks++; if (wr_enb !== (8'h01 << exp_idx[c]) || wr_data !== 8'(8'h10 + exp_idx[c])) begin
                errors++; $display("FAIL rr_write[%0d] got enb=%h data=%h want enb=%h data=%h", c, wr_enb, wr_data, 8'h01 << exp_idx[c], 8'(8'h10 + exp_idx[c]));
            end
        end
        req = '0;
        @(negedge clk);
        // rr_ptr is now 1
    endtask

    task automatic test_clear();
        clr_req = 1'b1;
        set_req(1, 3'd2, 8'h5C);
        set_req(0, 3'd6, 8'h3E);
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            clr_req = 1'b0;
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL clear_gnt[%0d] got %b want 0000", i, gnt); end
            checks++; if (wr_enb !== (8'h01 << i) || wr_data !== 8'h00 || busy !== 1'b1) begin
                errors++; $display("FAIL clear_walk[%0d] got enb=%h data=%h busy=%b want enb=%h data=00 busy=1", i, wr_enb, wr_data, busy, 8'h01 << i);
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || clr_done !== 1'b1) begin errors++; $display("FAIL clear_done got busy=%b done=%b want 0 1", busy, clr_done); end
        checks++; if (gnt !== 4'b0010 || wr_enb !== 8'h04 || wr_data !== 8'h5C) begin
            errors++; $display("FAIL clear_resume got gnt=%b enb=%h data=%h want 0010 04 5c", gnt, wr_enb, wr_data);
        end
        checks++; if (bank[5] !== 8'h00 || bank[0] !== 8'h00) begin errors++; $display("FAIL clear_bank got r5=%h r0=%h want 00 00", bank[5], bank[0]); end
        req[1] = 1'b0;
        @(negedge clk);
        checks++; if (clr_done !== 1'b0 || gnt !== 4'b0001 || wr_data !== 8'h3E) begin
            errors++; $display("FAIL clear_next got done=%b gnt=%b data=%h want 0 0001 3e", clr_done, gnt, wr_data);
        end
        req = '0;
        @(negedge clk);
        checks++; if (bank[2] !== 8'h5C) begin errors++; $display("FAIL clear_reg2 got %h want 5c", bank[2]); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        bit seen;
        clr_req = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            clr_req = 1'b0;
            if (wr_enb === 8'h04) seen = 1'b1;
            n++;
        end
        checks++; if (!seen) begin errors++; $display("FAIL midrst_wait got no wr_enb=04 want 04 within 20 cycles"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000 || wr_enb !== 8'h00 || wr_data !== 8'h00 || busy !== 1'b0 || clr_done !== 1'b0) begin
            errors++; $display("FAIL midrst_async got gnt=%b enb=%h data=%h busy=%b done=%b want all 0", gnt, wr_enb, wr_data, busy, clr_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        checks++; if (wr_enb !== 8'h01 || busy !== 1'b1) begin errors++; $display("FAIL midrst_restart got enb=%h busy=%b want 01 1", wr_enb, busy); end
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (clr_done === 1'b1) seen = 1'b1;
            n++;
        end
        checks++; if (!seen || n != NREG) begin errors++; $display("FAIL midrst_done got seen=%0d after %0d cycles want 1 after %0d", seen, n, NREG); end
    endtask

    task automatic test_same_addr();
        // rr_ptr is 0 here: reset cleared it and the sweep froze it
        set_req(0, 3'd3, 8'h11);
        set_req(3, 3'd3, 8'h22);
        @(negedge clk);
        checks++; if (gnt !== 4'b0001 || wr_enb !== 8'h08 || wr_data !== 8'h11) begin
            errors++; $display("FAIL same_first got gnt=%b enb=%h data=%h want 0001 08 11", gnt, wr_enb, wr_data);
        end
        req[0] = 1'b0;
        @(negedge clk);
        checks++; if (gnt !== 4'b1000 || wr_enb !== 8'h08 || wr_data !== 8'h22) begin
            errors++; $display("FAIL same_second got gnt=%b enb=%h data=%h want 1000 08 22", gnt, wr_enb, wr_data);
        end
        req = '0;
        @(negedge clk);
        checks++; if (bank[3] !== 8'h22) begin errors++; $display("FAIL same_reg3 got %h want 22", bank[3]); end
    endtask

    task automatic test_clear_retrigger();
        int writes;
        int dones;
        writes = 0;
        dones = 0;
        clr_req = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            clr_req = (c == 3) ? 1'b1 : 1'b0;
            if (wr_enb !== 8'h00) writes++;
            if (clr_done === 1'b1) dones++;
        end
        clr_req = 1'b0;
        checks++; if (writes != NREG) begin errors++; $display("FAIL retrig_writes got %0d want %0d", writes, NREG); end
        checks++; if (dones != 1) begin errors++; $display("FAIL retrig_done got %0d want 1", dones); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL retrig_idle got busy=%b want 0", busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_clear();
        test_reset_mid_clear();
        test_same_addr();
        test_clear_retrigger();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
